// File: rtl/trackball_pkg.sv
// Shared types and constants for the trackball receiver.
// Optional stability filter is enabled by defining TB_GLITCH_FILTER_EN.
package trackball_pkg;

    typedef logic [7:0] tb_count_t;

    localparam logic AXIS_H = 1'b0;
    localparam logic AXIS_V = 1'b1;

    localparam int TB_SYNC_MAX = 3;

    typedef enum logic {
        EDGE_LOW  = 1'b0,
        EDGE_HIGH = 1'b1
    } edge_state_e;

endpackage

// File: rtl/trackball_axis.sv
// One trackball axis: synchroniser, optional stability filter (TB_GLITCH_FILTER_EN),
// rising-edge FSM on the step clock and the 8-bit up/down position counter.
module trackball_axis
    import trackball_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int FILTER_LEN  = 3
) (
    input  logic      clk,
    input  logic      reset_n,
    input  logic      dir_i,
    input  logic      step_clk_i,
    input  logic      flip_i,
    output tb_count_t count_o,
    output logic      step_o
);

    localparam int SYNC_N = (SYNC_STAGES > TB_SYNC_MAX) ? TB_SYNC_MAX :
                            ((SYNC_STAGES < 2) ? 2 : SYNC_STAGES);

    logic [SYNC_N-1:0] dir_sync_q;
    logic [SYNC_N-1:0] clk_sync_q;
    logic [1:0]        raw_s;
    logic [1:0]        lvl_s;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            dir_sync_q <= '0;
            clk_sync_q <= '0;
        end else begin
            dir_sync_q <= {dir_sync_q[SYNC_N-2:0], dir_i};
            clk_sync_q <= {clk_sync_q[SYNC_N-2:0], step_clk_i};
        end
    end

    // bit 1 = direction, bit 0 = step clock; both paths see identical delay
    assign raw_s = {dir_sync_q[SYNC_N-1], clk_sync_q[SYNC_N-1]};

`ifdef TB_GLITCH_FILTER_EN
    localparam logic [3:0] FLT_LEN = 4'(FILTER_LEN);

    logic [1:0] filt_q;
    logic [1:0] filt_d;
    logic [3:0] fcnt_q [2];
    logic [3:0] fcnt_d [2];

    always_comb begin
        filt_d = filt_q;
        for (int i = 0; i < 2; i++) begin
            fcnt_d[i] = 4'd0;
            if (raw_s[i] != filt_q[i]) begin
                if (fcnt_q[i] + 4'd1 >= FLT_LEN) begin
                    filt_d[i] = raw_s[i];
                end else begin
                    fcnt_d[i] = fcnt_q[i] + 4'd1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            filt_q    <= '0;
            fcnt_q[0] <= '0;
            fcnt_q[1] <= '0;
        end else begin
            filt_q    <= filt_d;
            fcnt_q[0] <= fcnt_d[0];
            fcnt_q[1] <= fcnt_d[1];
        end
    end

    assign lvl_s = filt_q;
`else
    assign lvl_s = raw_s;
`endif

    edge_state_e state_q;
    edge_state_e state_d;
    logic        step_emit;
    logic        step_q;
    tb_count_t   count_q;
    tb_count_t   count_d;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= EDGE_LOW;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            EDGE_LOW:  if (lvl_s[0])  state_d = EDGE_HIGH;
            EDGE_HIGH: if (!lvl_s[0]) state_d = EDGE_LOW;
            default:   state_d = EDGE_LOW;
        endcase
    end

    always_comb begin
        step_emit = (state_q == EDGE_LOW) && lvl_s[0];
    end

    // direction and flip are sampled in the step cycle; the count moves on the next edge
    always_comb begin
        count_d = count_q;
        if (step_emit) begin
            count_d = (lvl_s[1] ^ flip_i) ? count_q + 8'd1 : count_q - 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            count_q <= '0;
            step_q  <= 1'b0;
        end else begin
            count_q <= count_d;
            step_q  <= step_emit;
        end
    end

    assign count_o = count_q;
    assign step_o  = step_q;

endmodule

// File: rtl/trackball_decoder.sv
// Trackball receiver top: two axis decoders, coherent snapshot read port and step pulse.
// Stability filter on the inputs is compiled in when TB_GLITCH_FILTER_EN is defined.
module trackball_decoder
    import trackball_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int FILTER_LEN  = 3
) (
    input  logic      clk,
    input  logic      reset_n,
    input  logic      h_dir_in,
    input  logic      h_clk_in,
    input  logic      v_dir_in,
    input  logic      v_clk_in,
    input  logic      flip,
    input  logic      rd_stb,
    input  logic      rd_sel,
    output tb_count_t rd_data,
    output tb_count_t h_count,
    output tb_count_t v_count,
    output logic      step_pulse
);

    logic h_step;
    logic v_step;

    trackball_axis #(
        .SYNC_STAGES (SYNC_STAGES),
        .FILTER_LEN  (FILTER_LEN)
    ) u_axis_h (
        .clk        (clk),
        .reset_n    (reset_n),
        .dir_i      (h_dir_in),
        .step_clk_i (h_clk_in),
        .flip_i     (flip),
        .count_o    (h_count),
        .step_o     (h_step)
    );

    trackball_axis #(
        .SYNC_STAGES (SYNC_STAGES),
        .FILTER_LEN  (FILTER_LEN)
    ) u_axis_v (
        .clk        (clk),
        .reset_n    (reset_n),
        .dir_i      (v_dir_in),
        .step_clk_i (v_clk_in),
        .flip_i     (flip),
        .count_o    (v_count),
        .step_o     (v_step)
    );

    tb_count_t h_snap_q, h_snap_d;
    tb_count_t v_snap_q, v_snap_d;
    tb_count_t rd_data_q, rd_data_d;

    // a horizontal read freezes both axes so the following vertical read is coherent
    always_comb begin
        h_snap_d  = h_snap_q;
        v_snap_d  = v_snap_q;
        rd_data_d = rd_data_q;
        if (rd_stb) begin
            if (rd_sel == AXIS_H) begin
                h_snap_d  = h_count;
                v_snap_d  = v_count;
                rd_data_d = h_count;
            end else begin
                rd_data_d = v_snap_q;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            h_snap_q  <= '0;
            v_snap_q  <= '0;
            rd_data_q <= '0;
        end else begin
            h_snap_q  <= h_snap_d;
            v_snap_q  <= v_snap_d;
            rd_data_q <= rd_data_d;
        end
    end

    assign rd_data    = rd_data_q;
    assign step_pulse = h_step | v_step;

endmodule

// File: tb/tb_trackball_decoder.sv
// Self-checking bench for trackball_decoder: directed steps plus randomized pulses
// checked against a modulo-256 position model.
module tb_trackball_decoder;

  localparam int SYNC_STAGES = 2;
  localparam int FILTER_LEN  = 3;
`ifdef TB_GLITCH_FILTER_EN
  localparam int LAT = SYNC_STAGES + 1 + FILTER_LEN;
`else
  localparam int LAT = SYNC_STAGES + 1;
`endif
  localparam int TIMEOUT_CYCLES = 200000;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       h_dir_in = 1'b0;
  logic       h_clk_in = 1'b0;
  logic       v_dir_in = 1'b0;
  logic       v_clk_in = 1'b0;
  logic       flip = 1'b0;
  logic       rd_stb = 1'b0;
  logic       rd_sel = 1'b0;
  logic [7:0] rd_data;
  logic [7:0] h_count;
  logic [7:0] v_count;
  logic       step_pulse;

  int checks = 0;
  int errors = 0;
  int pulse_cnt = 0;
  logic done = 1'b0;

  logic [7:0] exp_q[$];

  int h_m, v_m, hsnap_m, vsnap_m;

  trackball_decoder #(
    .SYNC_STAGES (SYNC_STAGES),
    .FILTER_LEN  (FILTER_LEN)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .h_dir_in   (h_dir_in),
    .h_clk_in   (h_clk_in),
    .v_dir_in   (v_dir_in),
    .v_clk_in   (v_clk_in),
    .flip       (flip),
    .rd_stb     (rd_stb),
    .rd_sel     (rd_sel),
    .rd_data    (rd_data),
    .h_count    (h_count),
    .v_count    (v_count),
    .step_pulse (step_pulse)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (reset_n && step_pulse === 1'b1) pulse_cnt <= pulse_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    int n;
    n = 0;
    while (!done && n < TIMEOUT_CYCLES) begin
      @(posedge clk);
      n++;
    end
    if (!done) begin
      errors++;
      $error("FAIL timeout: wait expired after %0d cycles", TIMEOUT_CYCLES);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    h_clk_in = 1'b0;
    v_clk_in = 1'b0;
    rd_stb = 1'b0;
    cyc(3);
    reset_n = 1'b1;
    h_m = 0; v_m = 0; hsnap_m = 0; vsnap_m = 0;
    cyc(1);
  endtask

  function automatic int step_model(input int cur, input logic dir, input logic flp);
    return (cur + ((dir ^ flp) ? 1 : 255)) % 256;
  endfunction

  task automatic pulse(input logic h_en, input logic v_en, input logic hd, input logic vd,
                       input int pre, input int hi, input int lo);
    if (h_en) h_dir_in = hd;
    if (v_en) v_dir_in = vd;
    cyc(pre);
    h_clk_in = h_en;
    v_clk_in = v_en;
    cyc(hi);
    h_clk_in = 1'b0;
    v_clk_in = 1'b0;
    cyc(lo);
    if (h_en) h_m = step_model(h_m, hd, flip);
    if (v_en) v_m = step_model(v_m, vd, flip);
  endtask

  task automatic do_read(input logic sel);
    rd_stb = 1'b1;
    rd_sel = sel;
    cyc(1);
    rd_stb = 1'b0;
    rd_sel = 1'b0;
    if (sel == 1'b0) begin
      hsnap_m = h_m;
      vsnap_m = v_m;
    end
  endtask

  initial begin
    int p0;
    logic he, ve, hd, vd, sel;
    logic [7:0] exp_v;

    do_reset();
    chk("reset_h_count", h_count, 8'h00);
    chk("reset_v_count", v_count, 8'h00);
    chk("reset_rd_data", rd_data, 8'h00);
    chk("reset_step_pulse", step_pulse, 1'b0);

    p0 = pulse_cnt;
    h_dir_in = 1'b1;
    cyc(2);
    h_clk_in = 1'b1;
    cyc(LAT - 1);
    chk("lat_before", h_count, 8'h00);
    cyc(1);
    chk("lat_at", h_count, 8'h01);
    chk("lat_pulse", step_pulse, 1'b1);
    cyc(1);
    chk("lat_pulse_drop", step_pulse, 1'b0);
    h_clk_in = 1'b0;
    cyc(4);
    h_m = 1;
    for (int i = 0; i < 4; i++) pulse(1'b1, 1'b0, 1'b1, 1'b0, 0, 4, 4);
    cyc(LAT);
    chk("five_h", h_count, 8'h05);
    chk("five_v", v_count, 8'h00);
    chk("five_pulses", pulse_cnt - p0, 5);

    pulse(1'b0, 1'b1, 1'b0, 1'b0, 2, 4, 6);
    chk("v_wrap_down", v_count, 8'hFF);
    pulse(1'b0, 1'b1, 1'b0, 1'b1, 2, 4, 6);
    chk("v_wrap_up", v_count, 8'h00);
    pulse(1'b0, 1'b1, 1'b0, 1'b1, 2, 4, 6);
    chk("v_up_one", v_count, 8'h01);

    do_reset();
    flip = 1'b1;
    for (int i = 0; i < 3; i++) pulse(1'b1, 1'b0, 1'b1, 1'b0, 2, 4, 6);
    chk("flip_h", h_count, 8'hFD);
    flip = 1'b0;

    do_reset();
    for (int i = 0; i < 16; i++) pulse(1'b1, 1'b1, 1'b1, 1'b1, 2, 4, 4);
    for (int i = 0; i < 16; i++) pulse(1'b0, 1'b1, 1'b0, 1'b1, 2, 4, 4);
    cyc(LAT);
    chk("pre_read_h", h_count, 8'h10);
    chk("pre_read_v", v_count, 8'h20);
    h_dir_in = 1'b1;
    cyc(2);
    h_clk_in = 1'b1;
    cyc(LAT - 1);
    rd_stb = 1'b1;
    rd_sel = 1'b0;
    cyc(1);
    rd_sel = 1'b1;
    chk("snap_rd_h", rd_data, 8'h10);
    chk("snap_h_after", h_count, 8'h11);
    cyc(1);
    rd_stb = 1'b0;
    rd_sel = 1'b0;
    chk("snap_rd_v", rd_data, 8'h20);
    h_clk_in = 1'b0;
    cyc(6);
    chk("rd_hold", rd_data, 8'h20);
    h_m = 17; v_m = 32; hsnap_m = 16; vsnap_m = 32;

    p0 = pulse_cnt;
    h_dir_in = 1'b1;
    v_dir_in = 1'b1;
    cyc(2);
    h_clk_in = 1'b1;
    v_clk_in = 1'b1;
    cyc(LAT - 1);
    chk("sim_h_before", h_count, 8'(h_m));
    chk("sim_v_before", v_count, 8'(v_m));
    cyc(1);
    chk("sim_h", h_count, 8'(h_m + 1));
    chk("sim_v", v_count, 8'(v_m + 1));
    chk("sim_pulse", step_pulse, 1'b1);
    cyc(1);
    chk("sim_pulse_drop", step_pulse, 1'b0);
    h_clk_in = 1'b0;
    v_clk_in = 1'b0;
    cyc(6);
    chk("sim_one_pulse", pulse_cnt - p0, 1);
    h_m = h_m + 1; v_m = v_m + 1;

`ifdef TB_GLITCH_FILTER_EN
    h_clk_in = 1'b1;
    cyc(2);
    h_clk_in = 1'b0;
    cyc(10);
    chk("glitch_rejected", h_count, 8'(h_m));
    h_clk_in = 1'b1;
    cyc(3);
    h_clk_in = 1'b0;
    cyc(LAT - 4);
    chk("filt_before", h_count, 8'(h_m));
    cyc(1);
    chk("filt_at", h_count, 8'(h_m + 1));
    cyc(8);
    h_m = h_m + 1;
`endif

    for (int i = 0; i < 40; i++) begin
      flip = 1'($urandom_range(0, 1));
      he = 1'($urandom_range(0, 1));
      ve = 1'($urandom_range(0, 1));
      hd = 1'($urandom_range(0, 1));
      vd = 1'($urandom_range(0, 1));
      p0 = pulse_cnt;
      pulse(he, ve, hd, vd, 2, $urandom_range(6, 10), $urandom_range(LAT + 1, LAT + 5));
      chk("rand_h", h_count, 8'(h_m));
      chk("rand_v", v_count, 8'(v_m));
      chk("rand_pulses", pulse_cnt - p0, (he | ve) ? 1 : 0);
      if ($urandom_range(0, 1) == 1) begin
        sel = 1'($urandom_range(0, 1));
        do_read(sel);
        exp_q.push_back((sel == 1'b0) ? 8'(hsnap_m) : 8'(vsnap_m));
        exp_v = exp_q.pop_front();
        chk("rand_read", rd_data, exp_v);
      end
    end
    flip = 1'b0;

    chk("scoreboard_empty", exp_q.size(), 0);

    done = 1'b1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    if (errors == 0) $display("TEST PASSED");
    else $display("TEST FAILED");
    $finish;
  end

endmodule

// File: doc/trackball_decoder.md
Name: trackball_decoder

Overview:
- Game-side receiver for the trackball direction/clock pairs (h_dir/h_clk, v_dir/v_clk) produced by the trackball emulator or SNAC port.
- Synchronises each pair, detects clock rising edges and keeps one 8-bit up/down position counter per axis, as the original LS191 counters do.
- Gives the CPU a coherent snapshot of both axes through a strobed read port.
- Sits inside the game module, between the top-level trackball signals and the CPU input decode.

Parameters:
- SYNC_STAGES, 2: flip-flop stages on each asynchronous input; legal values are 2 and 3.
- FILTER_LEN, 3: consecutive stable cycles required before an input change is accepted; used only when the filter macro is defined; range 1..15.

Ports:
- clk  in  1  game clock; everything is on the rising edge.
- reset_n  in  1  synchronous active-low reset.
- h_dir_in  in  1  horizontal direction, async; 1 = count up.
- h_clk_in  in  1  horizontal step clock, async; rising edge = one step.
- v_dir_in  in  1  vertical direction, async.
- v_clk_in  in  1  vertical step clock, async.
- flip  in  1  cocktail flip; inverts the meaning of both direction inputs.
- rd_stb  in  1  one-cycle CPU read strobe.
- rd_sel  in  1  0 = horizontal, 1 = vertical.
- rd_data  out  8  registered read data.
- h_count  out  8  live horizontal counter, for debug.
- v_count  out  8  live vertical counter, for debug.
- step_pulse  out  1  high for one cycle on any accepted step on either axis.

Behaviour:
- Reset (reset_n low at a clk edge): all synchroniser stages, filter counters, counters, snapshots, rd_data and step_pulse are cleared to 0. Each axis edge FSM goes to LOW. Reset has priority over every other event.
- Synchronisers: dir and clk of each axis use the same depth, SYNC_STAGES, so they stay aligned.
- Per-axis edge FSM, states LOW and HIGH:
  - LOW -> HIGH when the synchronised clock is 1; this emits a step.
  - HIGH -> LOW when the synchronised clock is 0.
  - A step samples the synchronised dir in the same cycle. Source requirement: dir must be set at least 1 clk before the clk rising edge.
- Count update:
  - Applied in the cycle after the step is emitted.
  - Effective direction = dir XOR flip. 1 means +1, 0 means -1.
  - Arithmetic is modulo 256: 0xFF + 1 = 0x00 and 0x00 - 1 = 0xFF.
  - Latency from the raw clk edge to the count change is SYNC_STAGES + 1 cycles (3 at default).
- step_pulse is asserted in the same cycle the counter changes. If both axes step in the same cycle, both counters update and step_pulse is a single pulse.
- Read port:
  - rd_stb with rd_sel = 0 copies both live counters into h_snap and v_snap, and rd_data <= the pre-update h_count.
  - rd_stb with rd_sel = 1 leaves the snapshots alone, and rd_data <= v_snap.
  - rd_data is valid the cycle after rd_stb and holds until the next rd_stb.
  - If a step and a snapshot happen in the same cycle, the snapshot takes the pre-update value and the counter still updates.
- Minimum resolvable step period is 2 × SYNC_STAGES cycles. Faster input is undefined, but the counters must not corrupt.
- Changing flip mid-stream affects only steps emitted after the change; existing counter values are untouched.

Optional Feature:
- Macro: TB_GLITCH_FILTER_EN.
- Defined:
  - Each synchronised input passes through a stability filter with a 4-bit counter.
  - The filtered output changes only after the new level has held for FILTER_LEN consecutive cycles.
  - Any bounce restarts the count.
  - Latency grows by FILTER_LEN cycles (6 at defaults).
- Undefined:
  - The filter logic is absent and FILTER_LEN is ignored.
  - Latency is as stated in Behaviour.

Decomposition:
- Package trackball_pkg holds:
  - typedef tb_count_t as logic [7:0];
  - localparams AXIS_H = 1'b0 and AXIS_V = 1'b1;
  - localparam TB_SYNC_MAX = 3.
- One sub-module, trackball_axis, is instantiated twice, once per axis. It contains the synchroniser, the optional filter, the edge FSM and the up/down counter. It outputs count and step.
- The top level holds the snapshot registers, the read mux and the step_pulse OR.

Test Plan:
- After reset, apply 5 h_clk rising edges with h_dir = 1 and flip = 0, 8 cycles apart: h_count = 0x05, v_count = 0x00, 5 step_pulses, and the first change appears 3 cycles after the first edge.
- From 0x00, apply 1 v_clk edge with v_dir = 0, then 2 with v_dir = 1: v_count goes 0xFF, 0x00, 0x01 (wrap both ways).
- With flip = 1, apply 3 h_clk edges with h_dir = 1: h_count = 0xFD.
- With h_count = 0x10 and v_count = 0x20, assert rd_stb/rd_sel = 0 in the same cycle an h step (up) takes effect, then rd_stb/rd_sel = 1: rd_data = 0x10, then 0x20; h_count = 0x11.
- Apply simultaneous h and v edges (both up): both counters +1 in the same cycle and exactly one step_pulse.
- With TB_GLITCH_FILTER_EN and FILTER_LEN = 3, apply a 2-cycle glitch high on h_clk: no count change. Then hold it high 3 cycles: +1, at 6 cycles after the edge.
